// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: owns the register bank write port, arbitrating pipeline writeback (A)
// against a long-latency unit (B), and tracks pending B destinations for issue hazards.
// Optional feature macro: RFARB_BYPASS_EN forwards the output-stage write instead of stalling.
`timescale 1ns/1ps
module regfile_write_arbiter #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_WIDTH    = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  aValid,
    output logic                  aReady,
    input  logic [4:0]            aRd,
    input  logic [DATA_WIDTH-1:0] aData,
    input  logic                  bValid,
    output logic                  bReady,
    input  logic [4:0]            bRd,
    input  logic [DATA_WIDTH-1:0] bData,
    input  logic                  issueValid,
    input  logic [4:0]            issueRd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    output logic                  hazard1,
    output logic                  hazard2,
    output logic                  writeRegister,
    output logic [4:0]            rd,
    output logic [DATA_WIDTH-1:0] dataToWrite,
    output logic                  bypassValid1,
    output logic                  bypassValid2,
    output logic [DATA_WIDTH-1:0] bypassData1,
    output logic [DATA_WIDTH-1:0] bypassData2
);

    localparam int unsigned REG_W    = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam logic [CNT_WIDTH-1:0] WAIT_LAST = CNT_WIDTH'(STARVE_LIMIT - 1);

    typedef enum logic [0:0] {
        NORMAL  = 1'b0,
        FORCE_B = 1'b1
    } state_t;

    typedef struct packed {
        logic [REG_W-1:0]      rd;
        logic [DATA_WIDTH-1:0] data;
    } wr_req_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  wait_q, wait_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic                  grant_a, grant_b;
    wr_req_t               win_req;
    logic                  win_write;
    logic                  out_we_q;
    wr_req_t               out_q;
    logic                  match1, match2;

    // State, starvation counter and scoreboard registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= NORMAL;
            wait_q    <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            pending_q <= pending_d;
        end
    end

    // Arbitration FSM: A wins by default, B is forced after STARVE_LIMIT consecutive losses
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        aReady  = 1'b0;
        bReady  = 1'b0;
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset) begin
            case (state_q)
                NORMAL: begin
                    aReady = 1'b1;
                    if (aValid) begin
                        grant_a = 1'b1;
                    end else if (bValid) begin
                        grant_b = 1'b1;
                        bReady  = 1'b1;
                    end
                    if (grant_b) begin
                        wait_d = '0;
                    end else if (bValid) begin
                        wait_d = wait_q + CNT_WIDTH'(1);
                        if (wait_q == WAIT_LAST) begin
                            state_d = FORCE_B;
                        end
                    end
                end
                FORCE_B: begin
                    // A dropped B request simply returns to NORMAL without a write
                    bReady  = bValid;
                    grant_b = bValid;
                    state_d = NORMAL;
                    wait_d  = '0;
                end
                default: begin
                    state_d = NORMAL;
                    wait_d  = '0;
                end
            endcase
        end
    end

    // Winning request; x0 grants are accepted but never written
    always_comb begin
        win_req.rd   = grant_a ? aRd : bRd;
        win_req.data = grant_a ? aData : bData;
        win_write    = (grant_a || grant_b) && (win_req.rd != '0);
    end

    // Output stage: rd/data hold their last value when nothing is written
    always_ff @(posedge clock) begin
        if (reset) begin
            out_we_q <= 1'b0;
            out_q    <= '0;
        end else begin
            out_we_q <= win_write;
            if (win_write) begin
                out_q <= win_req;
            end
        end
    end

    // The write sitting in the output stage is suppressed while reset is high
    assign writeRegister = out_we_q && !reset;
    assign rd            = out_q.rd;
    assign dataToWrite   = out_q.data;

    // Scoreboard update: a new issue to the same register wins over a B clear
    always_comb begin
        pending_d = pending_q;
        if (grant_b) begin
            pending_d[bRd] = 1'b0;
        end
        if (issueValid && (issueRd != '0)) begin
            pending_d[issueRd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        match1 = writeRegister && (rd == rs1) && (rs1 != '0);
        match2 = writeRegister && (rd == rs2) && (rs2 != '0);
`ifdef RFARB_BYPASS_EN
        hazard1      = (rs1 != '0) && pending_q[rs1];
        hazard2      = (rs2 != '0) && pending_q[rs2];
        bypassValid1 = match1;
        bypassValid2 = match2;
        bypassData1  = dataToWrite;
        bypassData2  = dataToWrite;
`else
        hazard1      = (rs1 != '0) && (pending_q[rs1] || match1);
        hazard2      = (rs2 != '0) && (pending_q[rs2] || match2);
        bypassValid1 = 1'b0;
        bypassValid2 = 1'b0;
        bypassData1  = '0;
        bypassData2  = '0;
`endif
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, then random traffic against a
// loss-counting reference model of arbitration, scoreboard and output stage.
`timescale 1ns/1ps
module tb_regfile_write_arbiter;

`ifdef RFARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int STARVE_LIMIT = 4;

    logic        clock, reset;
    logic        aValid, aReady, bValid, bReady, issueValid;
    logic [4:0]  aRd, bRd, issueRd, rs1, rs2, rd;
    logic [31:0] aData, bData, dataToWrite, bypassData1, bypassData2;
    logic        hazard1, hazard2, writeRegister, bypassValid1, bypassValid2;

    int vectors = 0;
    int miscompares = 0;

    regfile_write_arbiter dut (
        .clock(clock), .reset(reset),
        .aValid(aValid), .aReady(aReady), .aRd(aRd), .aData(aData),
        .bValid(bValid), .bReady(bReady), .bRd(bRd), .bData(bData),
        .issueValid(issueValid), .issueRd(issueRd), .rs1(rs1), .rs2(rs2),
        .hazard1(hazard1), .hazard2(hazard2),
        .writeRegister(writeRegister), .rd(rd), .dataToWrite(dataToWrite),
        .bypassValid1(bypassValid1), .bypassValid2(bypassValid2),
        .bypassData1(bypassData1), .bypassData2(bypassData2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst, av, bv, iv;
        logic [4:0]  ard, brd, ird, rs1, rs2;
        logic [31:0] adata, bdata;
        logic        ar, br, we, hp1, hp2;
        logic [4:0]  erd;
        logic [31:0] edata;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(input int rst, input int av, input int ard, input int adata,
                                input int bv, input int brd, input int bdata,
                                input int iv, input int ird, input int r1, input int r2,
                                input int ar, input int br, input int we, input int erd,
                                input int edata, input int hp1, input int hp2);
        vec_t v;
        v.rst = 1'(rst);   v.av = 1'(av);     v.ard = 5'(ard);   v.adata = 32'(adata);
        v.bv = 1'(bv);     v.brd = 5'(brd);   v.bdata = 32'(bdata);
        v.iv = 1'(iv);     v.ird = 5'(ird);   v.rs1 = 5'(r1);    v.rs2 = 5'(r2);
        v.ar = 1'(ar);     v.br = 1'(br);     v.we = 1'(we);     v.erd = 5'(erd);
        v.edata = 32'(edata); v.hp1 = 1'(hp1); v.hp2 = 1'(hp2);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic bv, input logic [4:0] br, input logic [31:0] bd,
                         input logic iv, input logic [4:0] ir, input logic [4:0] s1,
                         input logic [4:0] s2);
        reset = r; aValid = av; aRd = ar; aData = ad; bValid = bv; bRd = br; bData = bd;
        issueValid = iv; issueRd = ir; rs1 = s1; rs2 = s2;
    endtask

    // Checks every observable output against expected bank-side write and pending-only hazards
    task automatic check_all(input string tag, input logic ar, input logic br, input logic we,
                             input logic [4:0] erd, input logic [31:0] ed,
                             input logic hp1, input logic hp2);
        logic m1, m2;
        m1 = we && (erd == rs1) && (rs1 != 5'd0);
        m2 = we && (erd == rs2) && (rs2 != 5'd0);
        chk({tag, " aReady"}, 32'(aReady), 32'(ar));
        chk({tag, " bReady"}, 32'(bReady), 32'(br));
        chk({tag, " writeRegister"}, 32'(writeRegister), 32'(we));
        if (we) begin
            chk({tag, " rd"}, 32'(rd), 32'(erd));
            chk({tag, " dataToWrite"}, dataToWrite, ed);
        end
        chk({tag, " hazard1"}, 32'(hazard1), 32'((rs1 != 5'd0) && (hp1 || (!BYP && m1))));
        chk({tag, " hazard2"}, 32'(hazard2), 32'((rs2 != 5'd0) && (hp2 || (!BYP && m2))));
        chk({tag, " bypassValid1"}, 32'(bypassValid1), 32'(BYP && m1));
        chk({tag, " bypassValid2"}, 32'(bypassValid2), 32'(BYP && m2));
        if (!BYP || m1) chk({tag, " bypassData1"}, bypassData1, BYP ? ed : 32'd0);
        if (!BYP || m2) chk({tag, " bypassData2"}, bypassData2, BYP ? ed : 32'd0);
    endtask

    // Reference model state
    logic [31:0] m_pend;
    int          m_losses;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    initial begin
        logic        b_hold, forced, ga, gb, e_ar, e_br;
        logic [4:0]  b_rd;
        logic [31:0] b_data;

        //        rst av ard adata        bv brd bdata  iv ird rs1 rs2 | ar br we erd edata       hp1 hp2
        tbl[0]  = mk(1, 1, 0, 0,           1, 7, 0,     0, 0,  9,  9,   0, 0, 0, 0, 0,           0, 0);
        tbl[1]  = mk(1, 1, 0, 0,           1, 7, 0,     0, 0,  9,  9,   0, 0, 0, 0, 0,           0, 0);
        tbl[2]  = mk(0, 1, 5, 32'hDEADBEEF,0, 0, 0,     0, 0,  0,  0,   1, 0, 0, 0, 0,           0, 0);
        tbl[3]  = mk(0, 0, 0, 0,           0, 0, 0,     0, 0,  5,  0,   1, 0, 1, 5, 32'hDEADBEEF,0, 0);
        tbl[4]  = mk(0, 0, 0, 0,           0, 0, 0,     0, 0,  0,  0,   1, 0, 0, 0, 0,           0, 0);
        tbl[5]  = mk(0, 1, 1, 1,           1, 7, 'h77,  0, 0,  0,  0,   1, 0, 0, 0, 0,           0, 0);
        tbl[6]  = mk(0, 1, 2, 2,           1, 7, 'h77,  0, 0,  0,  0,   1, 0, 1, 1, 1,           0, 0);
        tbl[7]  = mk(0, 1, 3, 3,           1, 7, 'h77,  0, 0,  0,  0,   1, 0, 1, 2, 2,           0, 0);
        tbl[8]  = mk(0, 1, 4, 4,           1, 7, 'h77,  0, 0,  0,  0,   1, 0, 1, 3, 3,           0, 0);
        tbl[9]  = mk(0, 1, 5, 5,           1, 7, 'h77,  0, 0,  0,  0,   0, 1, 1, 4, 4,           0, 0);
        tbl[10] = mk(0, 0, 0, 0,           0, 0, 0,     0, 0,  0,  7,   1, 0, 1, 7, 'h77,        0, 0);
        tbl[11] = mk(0, 0, 0, 0,           0, 0, 0,     1, 9,  9,  0,   1, 0, 0, 0, 0,           0, 0);
        tbl[12] = mk(0, 0, 0, 0,           0, 0, 0,     0, 0,  9,  0,   1, 0, 0, 0, 0,           1, 0);
        tbl[13] = mk(0, 0, 0, 0,           1, 9, 'h99,  1, 9,  9,  0,   1, 1, 0, 0, 0,           1, 0);
        tbl[14] = mk(0, 0, 0, 0,           0, 0, 0,     0, 0,  9,  0,   1, 0, 1, 9, 'h99,        1, 0);
        tbl[15] = mk(0, 0, 0, 0,           0, 0, 0,     0, 0,  9,  0,   1, 0, 0, 0, 0,           1, 0);
        tbl[16] = mk(0, 0, 0, 0,           1, 9, 'hA,   0, 0,  9,  0,   1, 1, 0, 0, 0,           1, 0);
        tbl[17] = mk(0, 0, 0, 0,           0, 0, 0,     0, 0,  9,  0,   1, 0, 1, 9, 'hA,         0, 0);
        tbl[18] = mk(0, 0, 0, 0,           0, 0, 0,     0, 0,  9,  0,   1, 0, 0, 0, 0,           0, 0);
        tbl[19] = mk(0, 1, 0, 'h123,       0, 0, 0,     1, 0,  0,  0,   1, 0, 0, 0, 0,           0, 0);
        tbl[20] = mk(0, 0, 0, 0,           0, 0, 0,     0, 0,  0,  0,   1, 0, 0, 0, 0,           0, 0);
        tbl[21] = mk(0, 1, 3, 'h55,        0, 0, 0,     0, 0,  0,  0,   1, 0, 0, 0, 0,           0, 0);
        tbl[22] = mk(0, 0, 0, 0,           0, 0, 0,     0, 0,  0,  3,   1, 0, 1, 3, 'h55,        0, 0);
        tbl[23] = mk(0, 1, 6, 'h66,        0, 0, 0,     1, 12, 0,  0,   1, 0, 0, 0, 0,           0, 0);
        tbl[24] = mk(1, 0, 0, 0,           1, 13,'hD,   0, 0,  12, 6,   0, 0, 0, 0, 0,           1, 0);
        tbl[25] = mk(0, 0, 0, 0,           0, 0, 0,     0, 0,  12, 13,  1, 0, 0, 0, 0,           0, 0);

        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        @(posedge clock);
        #1;

        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].rst, tbl[i].av, tbl[i].ard, tbl[i].adata, tbl[i].bv, tbl[i].brd,
                  tbl[i].bdata, tbl[i].iv, tbl[i].ird, tbl[i].rs1, tbl[i].rs2);
            @(negedge clock);
            check_all($sformatf("row%0d", i), tbl[i].ar, tbl[i].br, tbl[i].we, tbl[i].erd,
                      tbl[i].edata, tbl[i].hp1, tbl[i].hp2);
            @(posedge clock);
            #1;
        end

        // Random phase; the table ends with everything cleared, matching a fresh model
        m_pend = '0; m_losses = 0; m_we = 1'b0; m_rd = '0; m_data = '0;
        b_hold = 1'b0; b_rd = '0; b_data = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!b_hold && ($urandom_range(0, 2) == 0)) begin
                b_hold = 1'b1;
                b_rd   = 5'($urandom_range(0, 7));
                b_data = $urandom;
            end
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 7)), $urandom,
                  b_hold && ($urandom_range(0, 11) != 0), b_rd, b_data,
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            @(negedge clock);

            forced = (m_losses >= STARVE_LIMIT);
            ga = 1'b0; gb = 1'b0; e_ar = 1'b0; e_br = 1'b0;
            if (!reset) begin
                if (forced) begin
                    gb = bValid;
                end else begin
                    e_ar = 1'b1;
                    ga = aValid;
                    gb = !aValid && bValid;
                end
                e_br = gb;
            end
            check_all($sformatf("rand%0d", c), e_ar, e_br, m_we && !reset, m_rd, m_data,
                      m_pend[rs1], m_pend[rs2]);

            if (reset) begin
                m_pend = '0; m_losses = 0; m_we = 1'b0; m_rd = '0; m_data = '0;
                b_hold = 1'b0;
            end else begin
                m_we = 1'b0;
                if (ga && aRd != 5'd0) begin m_we = 1'b1; m_rd = aRd; m_data = aData; end
                if (gb && bRd != 5'd0) begin m_we = 1'b1; m_rd = bRd; m_data = bData; end
                if (gb) begin
                    m_pend[bRd] = 1'b0;
                    b_hold = 1'b0;
                end
                if (issueValid && issueRd != 5'd0) m_pend[issueRd] = 1'b1;
                if (forced || gb) m_losses = 0;
                else if (bValid) m_losses = m_losses + 1;
            end
            @(posedge clock);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
